instr_fetch_queue: RTL and testbench

Instruction fetch stage between the PC logic and the decoder. It holds the fetch PC and drives the address of the combinational program ROM (32-bit words; unmapped addresses return NOP 32'h00000013). It captures each returned word with its PC into a small FIFO and presents it to decode over a valid/ready handshake. Redirects from execute, such as a taken `cnzdecj` loop branch, flush the queue and restart fetch at the target.

---
 rtl/instr_fetch_queue.sv | 79 +++++++
 tb/tb_instr_fetch_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Fetch stage: drives the ROM from fetch_pc and queues {pc, instr} for decode; 1-cycle fetch-to-issue latency.
// Stalls fetch (fetch_pc holds) while the queue is full and decode is not ready; a redirect flushes and costs one bubble.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int          PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW   = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_fetch_queue: DEPTH must be a power of two in 2..8");
  end

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;

  assign rom_addr = fetch_pc;
  assign if_valid = (count != '0);
  assign pop      = if_valid && if_ready;
  // A pop frees the slot this cycle, so a full queue can still accept the next word.
  assign push     = !redirect_valid && ((count < FULL) || pop);
  assign if_instr = if_valid ? instr_mem[rd_ptr] : NOP;
  assign if_pc    = if_valid ? pc_mem[rd_ptr] : 32'h00000000;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= rom_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed stimulus with a transfer scoreboard per DUT instance.
module tb_instr_fetch_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        ready_a, ready_b;
  logic        redir_a, redir_b;
  logic [31:0] redir_pc_a, redir_pc_b;
  logic [31:0] addr_a, addr_b, data_a, data_b;
  logic        valid_a, valid_b;
  logic [31:0] instr_a, instr_b, pc_a, pc_b;

  xfer_t sb_a[$];
  xfer_t sb_b[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00:  rom = 32'h00020137;
      32'h04:  rom = 32'h00110113;
      32'h08:  rom = 32'h00208193;
      32'h0C:  rom = 32'h00318213;
      32'h10:  rom = 32'h00420293;
      32'h14:  rom = 32'h00528313;
      32'h18:  rom = 32'h00630393;
      32'h1C:  rom = 32'h00738413;
      32'h20:  rom = 32'h00840493;
      32'h24:  rom = 32'h00948513;
      32'h28:  rom = 32'h00a50593;
      32'h2C:  rom = 32'h0001a203;
      default: rom = NOP;
    endcase
  endfunction

  assign data_a = rom(addr_a);
  assign data_b = rom(addr_b);

  instr_fetch_queue #(.RESET_PC(32'h00000000), .DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_a), .rom_addr(addr_a), .rom_data(data_a),
    .redirect_valid(redir_a), .redirect_pc(redir_pc_a),
    .if_valid(valid_a), .if_ready(ready_a), .if_instr(instr_a), .if_pc(pc_a)
  );

  instr_fetch_queue #(.RESET_PC(32'hFFFFFFF8), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_b), .rom_addr(addr_b), .rom_data(data_b),
    .redirect_valid(redir_b), .redirect_pc(redir_pc_b),
    .if_valid(valid_b), .if_ready(ready_b), .if_instr(instr_b), .if_pc(pc_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input logic [31:0] pc, input logic [31:0] instr);
    sb_a.push_back('{pc: pc, instr: instr});
  endtask

  task automatic exp_b(input logic [31:0] pc, input logic [31:0] instr);
    sb_b.push_back('{pc: pc, instr: instr});
  endtask

  // Monitors: every accepted transfer must match the next expected entry.
  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      if (sb_a.size() == 0) begin
        chk("a_unexpected_xfer_pc", pc_a, 32'hDEADBEEF);
      end else begin
        xfer_t e;
        e = sb_a.pop_front();
        chk("a_xfer_pc", pc_a, e.pc);
        chk("a_xfer_instr", instr_a, e.instr);
      end
    end
  end

  always @(negedge clk) begin
    if (valid_b && ready_b) begin
      if (sb_b.size() == 0) begin
        chk("b_unexpected_xfer_pc", pc_b, 32'hDEADBEEF);
      end else begin
        xfer_t e;
        e = sb_b.pop_front();
        chk("b_xfer_pc", pc_b, e.pc);
        chk("b_xfer_instr", instr_b, e.instr);
      end
    end
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0;
    redir_a = 1'b0; redir_b = 1'b0;
    redir_pc_a = '0; redir_pc_b = '0;

    // 1: reset and streaming
    step();
    ready_a = 1'b1;
    chk("t1_rst_rom_addr", addr_a, 32'h0);
    chk("t1_rst_valid", {31'b0, valid_a}, 32'h0);
    step();
    step();
    chk("t1_rst_instr", instr_a, NOP);
    chk("t1_rst_pc", pc_a, 32'h0);
    exp_a(32'h00, 32'h00020137);
    exp_a(32'h04, 32'h00110113);
    exp_a(32'h08, 32'h00208193);
    exp_a(32'h0C, 32'h00318213);
    exp_a(32'h10, 32'h00420293);
    exp_a(32'h14, 32'h00528313);
    rst_a = 1'b1;
    chk("t1_pre_edge0_valid", {31'b0, valid_a}, 32'h0);
    step();
    chk("t1_edge0_valid", {31'b0, valid_a}, 32'h1);
    chk("t1_edge0_pc", pc_a, 32'h0);
    step();
    chk("t1_edge1_pc", pc_a, 32'h4);
    for (int i = 0; i < 5; i++) step();
    ready_a = 1'b0;
    chk("t1_drained", sb_a.size(), 32'h0);

    // 2: stall and full
    rst_a = 1'b0;
    step();
    step();
    chk("t2_rst_valid", {31'b0, valid_a}, 32'h0);
    chk("t2_rst_rom_addr", addr_a, 32'h0);
    rst_a = 1'b1;
    step();
    chk("t2_edge0_rom_addr", addr_a, 32'h4);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_count", 32'(dut_a.count), 32'h2);
      chk("t2_stall_rom_addr", addr_a, 32'h8);
      chk("t2_stall_pc", pc_a, 32'h0);
      chk("t2_stall_valid", {31'b0, valid_a}, 32'h1);
      step();
    end
    exp_a(32'h00, 32'h00020137);
    exp_a(32'h04, 32'h00110113);
    exp_a(32'h08, 32'h00208193);
    exp_a(32'h0C, 32'h00318213);
    ready_a = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ready_a = 1'b0;
    chk("t2_drained", sb_a.size(), 32'h0);

    // 3: redirect with flush of a full queue
    redir_a = 1'b1; redir_pc_a = 32'h24;
    step();
    redir_a = 1'b0;
    chk("t3_flush_valid", {31'b0, valid_a}, 32'h0);
    chk("t3_flush_rom_addr", addr_a, 32'h24);
    step();
    chk("t3_fill_pc", pc_a, 32'h24);
    step();
    chk("t3_full_count", 32'(dut_a.count), 32'h2);
    step();
    chk("t3_hold_rom_addr", addr_a, 32'h2C);
    chk("t3_hold_pc", pc_a, 32'h24);
    exp_a(32'h24, 32'h00948513);
    exp_a(32'h2C, 32'h0001a203);
    ready_a = 1'b1; redir_a = 1'b1; redir_pc_a = 32'h2E;
    step();
    redir_a = 1'b0;
    chk("t3_bubble_valid", {31'b0, valid_a}, 32'h0);
    chk("t3_target_rom_addr", addr_a, 32'h2C);
    step();
    chk("t3_target_valid", {31'b0, valid_a}, 32'h1);
    chk("t3_target_pc", pc_a, 32'h2C);
    chk("t3_target_instr", instr_a, 32'h0001a203);
    step();
    ready_a = 1'b0;
    chk("t3_drained", sb_a.size(), 32'h0);

    // 4: back-to-back redirects, last one wins
    step();
    redir_a = 1'b1; redir_pc_a = 32'h10;
    step();
    redir_pc_a = 32'h2C;
    chk("t4_r1_valid", {31'b0, valid_a}, 32'h0);
    chk("t4_r1_rom_addr", addr_a, 32'h10);
    step();
    redir_a = 1'b0; ready_a = 1'b1;
    chk("t4_r2_valid", {31'b0, valid_a}, 32'h0);
    chk("t4_r2_rom_addr", addr_a, 32'h2C);
    exp_a(32'h2C, 32'h0001a203);
    exp_a(32'h30, NOP);
    exp_a(32'h34, NOP);
    step();
    chk("t4_first_pc", pc_a, 32'h2C);
    for (int i = 0; i < 3; i++) step();
    ready_a = 1'b0;
    chk("t4_drained", sb_a.size(), 32'h0);

    // 5: PC wrap-around on the second instance
    chk("t5_rst_rom_addr", addr_b, 32'hFFFFFFF8);
    chk("t5_rst_valid", {31'b0, valid_b}, 32'h0);
    exp_b(32'hFFFFFFF8, NOP);
    exp_b(32'hFFFFFFFC, NOP);
    exp_b(32'h00000000, 32'h00020137);
    exp_b(32'h00000004, 32'h00110113);
    rst_b = 1'b1; ready_b = 1'b1;
    for (int i = 0; i < 5; i++) step();
    ready_b = 1'b0;
    chk("t5_drained", sb_b.size(), 32'h0);

    // 6: reset coinciding with a redirect and a pop
    chk("t6_pre_count", 32'(dut_a.count), 32'h2);
    exp_a(32'h38, NOP);
    ready_a = 1'b1; redir_a = 1'b1; redir_pc_a = 32'h8; rst_a = 1'b0;
    step();
    redir_a = 1'b0;
    chk("t6_valid", {31'b0, valid_a}, 32'h0);
    chk("t6_rom_addr", addr_a, 32'h0);
    chk("t6_count", 32'(dut_a.count), 32'h0);
    chk("t6_instr", instr_a, NOP);
    chk("t6_pc", pc_a, 32'h0);
    exp_a(32'h00, 32'h00020137);
    rst_a = 1'b1;
    step();
    chk("t6_restart_pc", pc_a, 32'h0);
    step();
    ready_a = 1'b0;
    chk("t6_drained", sb_a.size(), 32'h0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
